// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one 8-bit ALU among N requesters.
// Optional macro ALU_ARB_OPCHECK_EN rejects opcodes 4'b1011..4'b1111 with rsp_err.
module alu_arbiter #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req_valid,
    output logic [N-1:0]   req_ready,
    input  logic [8*N-1:0] req_a,
    input  logic [8*N-1:0] req_b,
    input  logic [4*N-1:0] req_op,
    output logic [7:0]     alu_a,
    output logic [7:0]     alu_b,
    output logic [3:0]     alu_ctrl,
    input  logic [7:0]     alu_result,
    input  logic           alu_zero,
    input  logic           alu_ovf,
    input  logic           alu_carry,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [IDW-1:0] rsp_id,
    output logic [7:0]     rsp_result,
    output logic [2:0]     rsp_flags,
    output logic           rsp_err,
    output logic           busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t         state, state_nxt;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] gnt;
    logic           any;
    logic [7:0]     sel_a, sel_b;
    logic [3:0]     sel_op;
    logic           op_bad;
    logic           grant;

    // First valid requester at or after ptr, wrapping modulo N.
    always_comb begin : rr_search
        logic [IDW:0] idx;
        any = 1'b0;
        gnt = '0;
        idx = '0;
        for (int k = 0; k < N; k++) begin
            idx = {1'b0, ptr} + (IDW+1)'(k);
            if (idx >= (IDW+1)'(N))
                idx = idx - (IDW+1)'(N);
            if (!any && req_valid[idx[IDW-1:0]]) begin
                any = 1'b1;
                gnt = idx[IDW-1:0];
            end
        end
    end

    assign sel_a  = req_a[8*gnt +: 8];
    assign sel_b  = req_b[8*gnt +: 8];
    assign sel_op = req_op[4*gnt +: 4];
    assign grant  = (state == IDLE) && any;

`ifdef ALU_ARB_OPCHECK_EN
    assign op_bad = (sel_op >= 4'b1011);
`else
    assign op_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any) state_nxt = op_bad ? RESP : EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        rsp_valid = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE:    if (any) req_ready = N'(1) << gnt;
            RESP:    rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Grant captures operands and owner; EXEC captures the ALU outcome.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_ctrl   <= '0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_flags  <= '0;
        end else if (grant) begin
            ptr    <= (gnt == IDW'(N-1)) ? '0 : gnt + IDW'(1);
            rsp_id <= gnt;
            if (op_bad) begin
                rsp_result <= '0;
                rsp_flags  <= '0;
            end else begin
                alu_a    <= sel_a;
                alu_b    <= sel_b;
                alu_ctrl <= sel_op;
            end
        end else if (state == EXEC) begin
            rsp_result <= alu_result;
            rsp_flags  <= {alu_zero, alu_ovf, alu_carry};
        end
    end

`ifdef ALU_ARB_OPCHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rsp_err <= 1'b0;
        else if (grant)
            rsp_err <= op_bad;
    end
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table, corner sequences, randomized run vs. model.
module tb_alu_arbiter;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [8*N-1:0] req_a, req_b;
    logic [4*N-1:0] req_op;
    logic [7:0]     alu_a, alu_b, alu_result;
    logic [3:0]     alu_ctrl;
    logic           alu_zero, alu_ovf, alu_carry;
    logic           rsp_valid, rsp_ready, rsp_err, busy;
    logic [IDW-1:0] rsp_id;
    logic [7:0]     rsp_result;
    logic [2:0]     rsp_flags;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.N(N), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_ovf(alu_ovf), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err), .busy(busy)
    );

    // Behavioural ALU: returns {result, zero, ovf, carry}.
    function automatic logic [10:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        logic [8:0] s;
        logic [7:0] r;
        logic o, c;
        o = 1'b0; c = 1'b0; s = '0;
        case (op)
            4'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; o = (a[7] == b[7]) && (r[7] != a[7]); end
            4'd1: begin r = a - b; c = (a < b); o = (a[7] != b[7]) && (r[7] != a[7]); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            default: r = a;
        endcase
        return {r, (r == 8'h00), o, c};
    endfunction

    always_comb {alu_result, alu_zero, alu_ovf, alu_carry} = alu_f(alu_a, alu_b, alu_ctrl);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int id, input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        req_a[8*id +: 8]  = a;
        req_b[8*id +: 8]  = b;
        req_op[4*id +: 4] = op;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 10);
    endtask

    // One transaction from a single requester; starts and ends on a negedge in IDLE.
    task automatic run_one(input string tag, input int id, input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] op, input logic [7:0] res, input logic [2:0] flg,
                           input logic err, input int lat_exp);
        int lat;
        req_valid = '0;
        req_valid[id] = 1'b1;
        set_req(id, a, b, op);
        rsp_ready = 1'b1;
        #1 chk({tag, " grant"}, 32'(req_ready), 32'(1) << id);
        @(posedge clk);
        #1 req_valid = '0;
        wait_rsp(lat);
        chk({tag, " latency"}, lat, lat_exp);
        chk({tag, " id"}, 32'(rsp_id), id);
        chk({tag, " result"}, 32'(rsp_result), 32'(res));
        chk({tag, " flags"}, 32'(rsp_flags), 32'(flg));
        chk({tag, " err"}, 32'(rsp_err), 32'(err));
        @(negedge clk);
    endtask

    typedef struct {
        int         id;
        logic [7:0] a, b;
        logic [3:0] op;
        logic [7:0] res;
        logic [2:0] flg;
    } vec_t;

    vec_t tbl[7];

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat, w, seen, ptr_m;
        logic [7:0] ra[N];
        logic [7:0] rb[N];
        logic [3:0] ro[N];
        logic [N-1:0] mask;
        logic [10:0] expv;

        tbl[0] = '{2, 8'h7F, 8'h01, 4'd0, 8'h80, 3'b010};
        tbl[1] = '{1, 8'h05, 8'h05, 4'd1, 8'h00, 3'b100};
        tbl[2] = '{0, 8'hFF, 8'h01, 4'd0, 8'h00, 3'b101};
        tbl[3] = '{3, 8'h80, 8'h01, 4'd1, 8'h7F, 3'b010};
        tbl[4] = '{0, 8'hF0, 8'h3C, 4'd2, 8'h30, 3'b000};
        tbl[5] = '{3, 8'hF0, 8'h0F, 4'd3, 8'hFF, 3'b000};
        tbl[6] = '{1, 8'hAA, 8'hAA, 4'd4, 8'h00, 3'b100};

        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b0;
        #3;
        chk("reset ready", 32'(req_ready), 0);
        chk("reset alu", 32'({alu_a, alu_b, alu_ctrl}), 0);
        chk("reset rsp", 32'({rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err}), 0);
        chk("reset busy", 32'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++)
            run_one($sformatf("vec%0d", i), tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].op,
                    tbl[i].res, tbl[i].flg, 1'b0, 2);

`ifdef ALU_ARB_OPCHECK_EN
        run_one("badop", 2, 8'h12, 8'h34, 4'b1100, 8'h00, 3'b000, 1'b1, 1);
        chk("badop alu held", 32'({alu_a, alu_ctrl}), 32'({8'hAA, 4'd4}));
`else
        run_one("badop", 2, 8'h12, 8'h34, 4'b1100, 8'h12, 3'b000, 1'b0, 2);
        chk("badop alu issued", 32'({alu_a, alu_ctrl}), 32'({8'h12, 4'b1100}));
`endif

        // Round-robin with every requester valid from a fresh pointer.
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 8'(16*i + 1), 8'(i), 4'd0);
        req_valid = '1;
        #1;
        for (int g = 0; g < 5; g++) begin
            int e;
            e = g % N;
            w = 0;
            while (req_ready == '0 && w < 10) begin @(negedge clk); w++; end
            chk($sformatf("rr grant%0d", g), 32'(req_ready), 32'(1) << e);
            wait_rsp(lat);
            chk($sformatf("rr id%0d", g), 32'(rsp_id), e);
            chk($sformatf("rr res%0d", g), 32'(rsp_result), 32'(8'(17*e + 1)));
        end
        req_valid = '0;
        @(negedge clk);

        // Response back-pressure: outputs hold, no grants while stalled or on the handshake cycle.
        set_req(1, 8'h05, 8'h05, 4'd1);
        set_req(0, 8'h11, 8'h22, 4'd0);
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        #1 chk("stall grant", 32'(req_ready), 32'b0010);
        @(posedge clk);
        #1 req_valid = 4'b0001;
        wait_rsp(lat);
        chk("stall latency", lat, 2);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("stall hold%0d", c),
                32'({rsp_valid, rsp_id, rsp_result, rsp_flags, req_ready}),
                32'({1'b1, 2'd1, 8'h00, 3'b100, 4'b0000}));
        end
        rsp_ready = 1'b1;
        #1 chk("handshake no grant", 32'(req_ready), 0);
        @(posedge clk);
        #1 chk("after handshake", 32'({rsp_valid, req_ready}), 32'({1'b0, 4'b0001}));
        req_valid = '0;
        @(negedge clk);

        // Asynchronous reset while in EXEC.
        set_req(2, 8'h33, 8'h44, 4'd3);
        req_valid = 4'b0100;
        @(posedge clk);
        #2 req_valid = '0;
        chk("exec busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("areset busy", 32'(busy), 0);
        chk("areset alu", 32'({alu_a, alu_b, alu_ctrl}), 0);
        chk("areset rsp", 32'({rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err, req_ready}), 0);
        #1 rst_n = 1'b1;
        seen = 0;
        repeat (6) begin @(negedge clk); if (rsp_valid) seen++; end
        chk("no rsp after reset", seen, 0);

        // Randomized traffic against a pointer/winner model; pointer is 0 after reset.
        ptr_m = 0;
        for (int t = 0; t < 60; t++) begin
            mask = N'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) begin
                ra[i] = 8'($urandom); rb[i] = 8'($urandom); ro[i] = 4'($urandom_range(0, 10));
                set_req(i, ra[i], rb[i], ro[i]);
            end
            req_valid = mask;
            #1;
            if (mask == '0) begin
                chk($sformatf("rnd%0d idle", t), 32'(req_ready), 0);
                @(negedge clk);
                continue;
            end
            w = -1;
            for (int k = 0; k < N; k++)
                if (w < 0 && mask[(ptr_m + k) % N]) w = (ptr_m + k) % N;
            ptr_m = (w + 1) % N;
            expv = alu_f(ra[w], rb[w], ro[w]);
            chk($sformatf("rnd%0d grant", t), 32'(req_ready), 32'(1) << w);
            rsp_ready = 1'($urandom);
            @(posedge clk);
            #1 req_valid = '0;
            wait_rsp(lat);
            chk($sformatf("rnd%0d rsp", t), 32'({rsp_valid, rsp_id, rsp_result, rsp_flags}),
                32'({1'b1, 2'(w), expv}));
            if (!rsp_ready) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
                chk($sformatf("rnd%0d held", t), 32'({rsp_valid, rsp_id, rsp_result, rsp_flags}),
                    32'({1'b1, 2'(w), expv}));
                rsp_ready = 1'b1;
            end
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer that shares one 8-bit combinational ALU among N requesters. Each requester issues operand/opcode transactions over a valid/ready handshake. The block registers the winning transaction onto the ALU inputs, captures the result and the Zero/Overflow/Carry flags one cycle later, and returns them on a shared response channel tagged with the requester ID. It sits between client engines and the single ALU instance; the ALU is instantiated beside it and wired through the `alu_*` ports.

## Interface
- `N`, 4: number of requesters, 2..8.
- `IDW`, `$clog2(N)`: width of the requester ID.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in N: per-requester transaction valid.
- `req_ready` out N: per-requester accept, one-hot or zero.
- `req_a` in 8*N: operand A, requester i at `[8i+7:8i]`.
- `req_b` in 8*N: operand B, same packing.
- `req_op` in 4*N: ALU control code, requester i at `[4i+3:4i]`.
- `alu_a` out 8: registered operand A to the ALU.
- `alu_b` out 8: registered operand B to the ALU.
- `alu_ctrl` out 4: registered control code to the ALU.
- `alu_result` in 8: ALU result.
- `alu_zero`, `alu_ovf`, `alu_carry` in 1 each: ALU flags.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response accept.
- `rsp_id` out IDW: index of the requester that owns the response.
- `rsp_result` out 8: captured result.
- `rsp_flags` out 3: captured flags as `{zero, ovf, carry}`.
- `rsp_err` out 1: illegal-opcode indication (see Configuration).
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any `req_valid` bit is set, select the winner g by round-robin search starting at `ptr`, in order ptr, ptr+1, … mod N.
  - Assert `req_ready[g]` only.
  - Latch `req_a/b/op[g]` into `alu_a/b/ctrl` and g into `rsp_id`.
  - Set `ptr` to (g+1) mod N, then go to EXEC.
- EXEC: hold `alu_*` stable. At the cycle end, capture `alu_result` into `rsp_result` and the three flags into `rsp_flags`. Go to RESP.
- RESP:
  - Assert `rsp_valid`; hold all `rsp_*` outputs stable while `rsp_ready` is low.
  - On `rsp_valid && rsp_ready`, return to IDLE.
  - No new grant is made in the cycle of the response handshake.
- `alu_*` outputs hold their last values until the next grant.
- `req_ready` is combinational from `req_valid`, the state and `ptr`. It is never asserted outside IDLE.
- Requesters must hold their request stable until `req_ready`. Dropping `req_valid` before the grant is legal and simply removes that requester from arbitration.
- Single requester: it wins every time, regardless of `ptr`.
- All N requesters continuously valid: grants rotate 0,1,…,N-1,0. No requester waits more than N−1 other grants.

## Timing
- Reset values: `req_ready` = 0, `alu_a/b/ctrl` = 0, `rsp_valid` = 0, `rsp_id` = 0, `rsp_result` = 0, `rsp_flags` = 0, `rsp_err` = 0, `busy` = 0, `ptr` = 0, state = IDLE.
- Latency: with `rsp_ready` held high, the response is valid 2 cycles after the grant cycle.
- Minimum issue interval is 3 cycles per transaction.
- Reset asserted mid-transaction: the in-flight transaction is discarded and no response is produced. All registers take their reset values immediately, without waiting for a clock edge.

## Configuration
- Macro: `ALU_ARB_OPCHECK_EN`.
- Defined:
  - A granted opcode in the range 4'b1011..4'b1111 is not issued; `alu_*` keep their previous values.
  - The FSM goes IDLE→RESP directly with `rsp_result` = 0, `rsp_flags` = 0, `rsp_err` = 1.
  - Legal opcodes give `rsp_err` = 0.
- Undefined: every opcode is issued through EXEC, and `rsp_err` is tied to 0.

## Test plan
- Reset then single request: requester 2 issues A=0x7F, B=0x01, op=4'b0000. Required: grant in 1 cycle, response 2 cycles later with `rsp_id`=2, result 0x80, flags 3'b010.
- All 4 requesters held valid, `rsp_ready`=1: grants in order 0,1,2,3,0, and each response carries the matching `rsp_id`.
- Subtract A=0x05, B=0x05 (op 4'b0001): result 0x00, zero=1. Hold `rsp_ready`=0 for 5 cycles; `rsp_*` stay stable and `req_ready` stays 0 throughout.
- Async reset asserted in EXEC: all outputs return to reset values without a clock edge, and no `rsp_valid` appears afterwards.
- With `ALU_ARB_OPCHECK_EN`, op=4'b1100: response in 1 cycle with `rsp_err`=1 and result 0x00. Without the macro, the same op gives `rsp_err`=0 and the response follows the EXEC path.
